// File: rtl/seg_pkg.sv
// Shared 7-segment constants (active-low {dp,g,f,e,d,c,b,a}) used by display blocks.
package seg_pkg;

  localparam int DIG_NUM = 6;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD nibble to active-low a..g segments; non-decimal nibbles show a dash.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH[6:0];
    case (bcd)
      4'd0:    seg = SEG_0[6:0];
      4'd1:    seg = SEG_1[6:0];
      4'd2:    seg = SEG_2[6:0];
      4'd3:    seg = SEG_3[6:0];
      4'd4:    seg = SEG_4[6:0];
      4'd5:    seg = SEG_5[6:0];
      4'd6:    seg = SEG_6[6:0];
      4'd7:    seg = SEG_7[6:0];
      4'd8:    seg = SEG_8[6:0];
      4'd9:    seg = SEG_9[6:0];
      default: seg = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed common-anode 7-segment driver with per-frame snapshot and slot blanking.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_SCAN  = 16'd50000,
  parameter logic [15:0] BLANK_CYC = 16'd500
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] bcd_data,
  input  logic [5:0]  point,
  input  logic        seg_en,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_led
);

  logic [15:0] cnt_scan;
  logic [2:0]  dig_idx;
  logic [23:0] shadow_bcd;
  logic [5:0]  shadow_point;
  logic        first_cyc;

  logic        wrap;
  logic        last_dig;
  logic        capture;
  logic [23:0] bcd_shift;
  logic [3:0]  cur_nib;
  logic [6:0]  cur_seg;
  logic        cur_dp;
  logic [5:0]  lzb_mask;
  logic [5:0]  sel_next;
  logic [7:0]  led_next;

  assign wrap     = (cnt_scan == CNT_SCAN - 16'd1);
  assign last_dig = (dig_idx == 3'(DIG_NUM - 1));
  // first_cyc forces a capture right after reset so the first frame is never stale zeros
  assign capture  = first_cyc | (wrap & last_dig);

  assign bcd_shift = shadow_bcd >> {dig_idx, 2'b00};
  assign cur_nib   = bcd_shift[3:0];
  assign cur_dp    = shadow_point[dig_idx];

  seg_decode u_decode (
    .bcd (cur_nib),
    .seg (cur_seg)
  );

`ifdef SEG_LZB_EN
  logic zero_run;

  // Walk from the most significant digit down; blank while everything above is zero and dp-free
  always_comb begin
    lzb_mask = '0;
    zero_run = 1'b1;
    for (int i = DIG_NUM - 1; i >= 1; i--) begin
      zero_run    = zero_run & (shadow_bcd[4*i +: 4] == 4'd0) & ~shadow_point[i];
      lzb_mask[i] = zero_run;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  always_comb begin
    sel_next = 6'h3F;
    led_next = SEG_OFF;
    if (seg_en) begin
      sel_next = ~(6'b000001 << dig_idx);
      if (!(cnt_scan < BLANK_CYC) && !lzb_mask[dig_idx]) begin
        led_next = {~cur_dp, cur_seg};
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_scan     <= '0;
      dig_idx      <= '0;
      shadow_bcd   <= '0;
      shadow_point <= '0;
      first_cyc    <= 1'b1;
      seg_sel      <= 6'h3F;
      seg_led      <= SEG_OFF;
    end else begin
      first_cyc <= 1'b0;
      if (wrap) begin
        cnt_scan <= '0;
        dig_idx  <= last_dig ? 3'd0 : dig_idx + 3'd1;
      end else begin
        cnt_scan <= cnt_scan + 16'd1;
      end
      if (capture) begin
        shadow_bcd   <= bcd_data;
        shadow_point <= point;
      end
      seg_sel <= sel_next;
      seg_led <= led_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: table vectors, corner sequences and random stimulus.
module tb_seg_scan_driver;

  localparam int CNT   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 6 * CNT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] bcd_data = '0;
  logic [5:0]  point = '0;
  logic        seg_en = 1'b1;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;

  int total = 0;
  int bad = 0;

  seg_scan_driver #(.CNT_SCAN(16'd8), .BLANK_CYC(16'd2)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bcd_data  (bcd_data),
    .point     (point),
    .seg_en    (seg_en),
    .seg_sel   (seg_sel),
    .seg_led   (seg_led)
  );

  always #5 clk = ~clk;

  logic [7:0] dec_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Expected lit pattern for digit d of a frame snapshot
  function automatic logic [7:0] ref_code(logic [23:0] b, logic [5:0] p, int d);
    int nib;
    logic [7:0] code;
    nib  = int'((b >> (4 * d)) & 24'hF);
    code = (nib <= 9) ? dec_tab[nib] : 8'hBF;
    if (p[d]) code[7] = 1'b0;
`ifdef SEG_LZB_EN
    if (d >= 1 && (b >> (4 * d)) == 24'd0 && (p >> d) == 6'd0) code = 8'hFF;
`endif
    return code;
  endfunction

  // Reference model: t = number of scan cycles elapsed since reset release
  int         t = 0;
  logic [23:0] m_bcd = '0;
  logic [5:0]  m_pt = '0;
  logic [5:0]  exp_sel = 6'h3F;
  logic [7:0]  exp_led = 8'hFF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; m_bcd = '0; m_pt = '0; exp_sel = 6'h3F; exp_led = 8'hFF;
    end else begin
      if (!seg_en) begin
        exp_sel = 6'h3F; exp_led = 8'hFF;
      end else begin
        exp_sel = 6'h3F ^ (6'd1 << ((t / CNT) % 6));
        exp_led = ((t % CNT) < BLANK) ? 8'hFF : ref_code(m_bcd, m_pt, (t / CNT) % 6);
      end
      if (t == 0 || (t % FRAME) == FRAME - 1) begin
        m_bcd = bcd_data; m_pt = point;
      end
      t++;
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0d)", name, got, want, t);
    end
  endtask

  task automatic step_chk(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("model_sel", {2'b00, seg_sel}, {2'b00, exp_sel});
      check("model_led", seg_led, exp_led);
    end
  endtask

  // Run until the output just produced belongs to frame phase ph (bounded)
  task automatic wait_phase(input int ph);
    int n = 0;
    do begin
      step_chk(1);
      n++;
    end while (((t - 1) % FRAME) != ph && n < 2 * FRAME);
    if (((t - 1) % FRAME) != ph) begin
      bad++; total++;
      $display("FAIL wait_phase got=%0d want=%0d", (t - 1) % FRAME, ph);
    end
  endtask

  typedef struct packed {
    logic [23:0]     bcd;
    logic [5:0]      pt;
    logic [5:0][7:0] exp;
    logic [5:0][7:0] lzb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] want;
    int s, d;
    // exp/lzb listed digit 5 first, digit 0 last
    vecs[0] = '{24'h012345, 6'b000000, {8'hC0,8'hF9,8'hA4,8'hB0,8'h99,8'h92}, {8'hFF,8'hF9,8'hA4,8'hB0,8'h99,8'h92}};
    vecs[1] = '{24'h00000A, 6'b000100, {8'hC0,8'hC0,8'hC0,8'h40,8'hC0,8'hBF}, {8'hFF,8'hFF,8'hFF,8'h40,8'hC0,8'hBF}};
    vecs[2] = '{24'h000120, 6'b000000, {8'hC0,8'hC0,8'hC0,8'hF9,8'hA4,8'hC0}, {8'hFF,8'hFF,8'hFF,8'hF9,8'hA4,8'hC0}};
    vecs[3] = '{24'h000120, 6'b010000, {8'hC0,8'h40,8'hC0,8'hF9,8'hA4,8'hC0}, {8'hFF,8'h40,8'hC0,8'hF9,8'hA4,8'hC0}};
    vecs[4] = '{24'h999999, 6'b111111, {8'h10,8'h10,8'h10,8'h10,8'h10,8'h10}, {8'h10,8'h10,8'h10,8'h10,8'h10,8'h10}};
    vecs[5] = '{24'hFEDCBA, 6'b100001, {8'h3F,8'hBF,8'hBF,8'hBF,8'hBF,8'h3F}, {8'h3F,8'hBF,8'hBF,8'hBF,8'hBF,8'h3F}};
    vecs[6] = '{24'h000000, 6'b000000, {8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0}, {8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hC0}};
    vecs[7] = '{24'h678900, 6'b000000, {8'h82,8'hF8,8'h80,8'h90,8'hC0,8'hC0}, {8'h82,8'hF8,8'h80,8'h90,8'hC0,8'hC0}};

    // Reset state
    bcd_data = 24'h012345; point = '0; seg_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_sel", {2'b00, seg_sel}, 8'h3F);
    check("reset_led", seg_led, 8'hFF);
    rst_n = 1'b1;

    // First frame after release: blank window then digit 0 shows 5
    step_chk(1);
    check("first_sel", {2'b00, seg_sel}, 8'h3E);
    check("first_blank", seg_led, 8'hFF);
    step_chk(2);
    check("first_dig0", seg_led, 8'h92);
    step_chk(FRAME);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      bcd_data = vecs[i].bcd; point = vecs[i].pt;
      wait_phase(FRAME - 1);
      for (int k = 0; k < FRAME; k++) begin
        step_chk(1);
        s = t - 1;
        if ((s % CNT) == 4) begin
          d = (s / CNT) % 6;
`ifdef SEG_LZB_EN
          want = vecs[i].lzb[d];
`else
          want = vecs[i].exp[d];
`endif
          check($sformatf("vec%0d_dig%0d", i, d), seg_led, want);
        end
      end
    end

    // Mid-frame change must not tear the current frame
    bcd_data = 24'h012345; point = '0;
    wait_phase(FRAME - 1);
    wait_phase(18);
    bcd_data = 24'h999999;
    wait_phase(28);
    check("tear_dig3_old", seg_led, 8'hA4);
    wait_phase(4);
    check("tear_dig0_new", seg_led, 8'h90);

    // seg_en low for 20 cycles mid-frame, then resume without restart
    wait_phase(10);
    seg_en = 1'b0;
    step_chk(1);
    check("en_off_sel", {2'b00, seg_sel}, 8'h3F);
    check("en_off_led", seg_led, 8'hFF);
    step_chk(19);
    seg_en = 1'b1;
    step_chk(1);
    check("en_resume_sel", {2'b00, seg_sel}, 8'h37);
    check("en_resume_led", seg_led, 8'h90);

    // seg_en toggling on the frame-start capture edge still captures
    wait_phase(FRAME - 2);
    seg_en = 1'b0; bcd_data = 24'h000321;
    step_chk(1);
    seg_en = 1'b1;
    wait_phase(4);
    check("en_capture_dig0", seg_led, 8'hF9);

    // Asynchronous reset mid-slot of digit 3
    wait_phase(27);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sel", {2'b00, seg_sel}, 8'h3F);
    check("async_rst_led", seg_led, 8'hFF);
    bcd_data = 24'h000456;
    @(negedge clk);
    rst_n = 1'b1;
    step_chk(1);
    check("restart_sel", {2'b00, seg_sel}, 8'h3E);
    check("restart_led", seg_led, 8'hFF);
    wait_phase(4);
    check("restart_dig0", seg_led, 8'h82);

    // Randomized stimulus against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        bcd_data = 24'($urandom);
        point    = 6'($urandom);
      end
      if ($urandom_range(0, 31) == 0) seg_en = ~seg_en;
      step_chk(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
